// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
// Display stage for a 4-digit BCD counter. It time-multiplexes the four digits
// onto a common-anode 4-digit 7-segment display, with these features:
//   - All four digits are snapshotted once per scan frame, so a count never
//     tears across digits.
//   - Every digit slot opens with an all-anodes-off blanking gap, which
//     prevents ghosting.
//   - BCD values are decoded to active-low segments.
//   - Codes A..F show a dash.
// Optional feature (compile-time macro): LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (thousands, hundreds, tens) are blanked.
//   The ones digit is always shown.

module seven_seg_scanner #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] CNT1,
  input  logic [3:0] CNT2,
  input  logic [3:0] CNT3,
  input  logic [3:0] CNT4,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       FRAME
);

  localparam int              DIV_W     = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_VAL = DIV_W'(BLANK_CYC);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  // Two phases inside every digit slot
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic             first_cycle;
  logic [3:0][3:0]  shadow;

  logic             div_wrap;
  logic             frame_take;
  phase_t           phase;
  logic [3:0]       cur_digit;
  logic             lz_blank;
  logic [3:0]       next_an;
  logic [6:0]       next_seg;

  // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign div_wrap   = (div == DIV_LAST);
  assign frame_take = first_cycle | (div_wrap & (idx == 2'd3));

  // Slot prescaler and digit index; first_cycle forces a snapshot right after reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div         <= '0;
      idx         <= 2'd0;
      first_cycle <= 1'b1;
    end else begin
      first_cycle <= 1'b0;
      if (div_wrap) begin
        div <= '0;
        idx <= idx + 2'd1;
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // Shadow copy of all four digits, refreshed only at frame boundaries
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shadow <= '0;
    end else if (frame_take) begin
      shadow <= {CNT4, CNT3, CNT2, CNT1};
    end
  end

  assign cur_digit = shadow[idx];

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every higher digit are zero
  always_comb begin
    lz_blank = 1'b0;
    case (idx)
      2'd3:    lz_blank = (shadow[3] == 4'd0);
      2'd2:    lz_blank = (shadow[3] == 4'd0) && (shadow[2] == 4'd0);
      2'd1:    lz_blank = (shadow[3] == 4'd0) && (shadow[2] == 4'd0) &&
                          (shadow[1] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  // Next anode/segment pattern from the current slot phase and digit
  always_comb begin
    next_an  = AN_OFF;
    next_seg = SEG_OFF;
    phase    = (div < BLANK_VAL) ? PH_BLANK : PH_DRIVE;
    if (phase == PH_DRIVE) begin
      next_an       = AN_OFF;
      next_an[idx]  = 1'b0;
      next_seg      = lz_blank ? SEG_OFF : bcd_to_seg(cur_digit);
    end
  end

  // Registered display outputs; reset turns everything off immediately
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      AN    <= AN_OFF;
      SEG   <= SEG_OFF;
      FRAME <= 1'b0;
    end else begin
      AN    <= next_an;
      SEG   <= next_seg;
      FRAME <= frame_take;
    end
  end

  assign DP = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Testbench for seven_seg_scanner with SCAN_DIV=8, BLANK_CYC=2.
// Expectations follow LEADING_ZERO_BLANK_EN when it is defined for the build.

module tb_seven_seg_scanner;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] cnt1, cnt2, cnt3, cnt4;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP;
  logic       FRAME;

  int         total = 0;
  int         bad = 0;
  int         edgeNum = 0;
  logic [3:0] modelShadow [4];

  seven_seg_scanner #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .CNT1(cnt1), .CNT2(cnt2), .CNT3(cnt3), .CNT4(cnt4),
    .AN(AN), .SEG(SEG), .DP(DP), .FRAME(FRAME)
  );

  // 10-unit clock period
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, observed, expected, edgeNum);
    end
  endtask

  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic blankOf(input int idx);
`ifdef LEADING_ZERO_BLANK_EN
    logic z = 1'b1;
    if (idx == 0) return 1'b0;
    for (int k = 3; k >= idx; k--) z = z & (modelShadow[k] == 4'd0);
    return z;
`else
    return (idx < 0);
`endif
  endfunction

  task automatic applyStimulus(input logic [3:0] d4, input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1);
    cnt4 = d4;
    cnt3 = d3;
    cnt2 = d2;
    cnt1 = d1;
  endtask

  // One clock edge; expected outputs derive from the edge count since reset release
  task automatic stepCheck(input string tag);
    int         p, dv, ix;
    logic       frameNow;
    logic [3:0] oneHot, expAn;
    logic [6:0] expSeg;
    p        = edgeNum;
    dv       = p % 8;
    ix       = (p / 8) % 4;
    frameNow = (p == 0) || (dv == 7 && ix == 3);
    if (dv < 2) begin
      expAn  = 4'b1111;
      expSeg = 7'h7F;
    end else begin
      oneHot = 4'b0001 << ix;
      expAn  = ~oneHot;
      expSeg = blankOf(ix) ? 7'h7F : segOf(modelShadow[ix]);
    end
    @(posedge CLK);
    #1;
    edgeNum++;
    checkOutput({tag, "_an"}, {28'd0, AN}, {28'd0, expAn});
    checkOutput({tag, "_seg"}, {25'd0, SEG}, {25'd0, expSeg});
    checkOutput({tag, "_frame"}, {31'd0, FRAME}, {31'd0, frameNow});
    if (frameNow) begin
      modelShadow[0] = cnt1;
      modelShadow[1] = cnt2;
      modelShadow[2] = cnt3;
      modelShadow[3] = cnt4;
    end
  endtask

  task automatic runEdges(input string tag, input int n);
    for (int i = 0; i < n; i++) stepCheck(tag);
  endtask

  task automatic checkOff(input string tag);
    checkOutput({tag, "_an"}, {28'd0, AN}, 32'hF);
    checkOutput({tag, "_seg"}, {25'd0, SEG}, 32'h7F);
    checkOutput({tag, "_dp"}, {31'd0, DP}, 32'h1);
    checkOutput({tag, "_frame"}, {31'd0, FRAME}, 32'h0);
  endtask

  task automatic releaseReset();
    @(negedge CLK);
    RESET = 1'b0;
    edgeNum = 0;
    for (int k = 0; k < 4; k++) modelShadow[k] = 4'd0;
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus(4'd4, 4'd3, 4'd2, 4'd1);
    RESET = 1'b1;
    #1;
    checkOff("rst_async");

    releaseReset();
    runEdges("basic", 50);

    applyStimulus(4'd4, 4'd3, 4'd2, 4'd7);
    runEdges("midframe", 46);

    applyStimulus(4'd4, 4'd3, 4'd2, 4'hA);
    runEdges("dash", 64);
    applyStimulus(4'd4, 4'd3, 4'd2, 4'd0);
    runEdges("zero", 64);

    applyStimulus(4'd0, 4'd0, 4'd0, 4'd5);
    runEdges("lz_all", 64);
    applyStimulus(4'd0, 4'd1, 4'd0, 4'd5);
    runEdges("lz_part", 64);

    runEdges("pre_rst", 21);
    checkOutput("pre_rst_idx2_drive", {28'd0, AN}, 32'hB);
    RESET = 1'b1;
    #1;
    checkOff("rst_mid");
    releaseReset();
    runEdges("post_rst", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
